// File: rtl/alu_pkg.sv
// Shared definitions for the alu_unit execution unit: opcodes, FSM states and
// the combinational single-cycle result function.
package alu_pkg;

    localparam int OPCODE_WIDTH = 5;
    localparam int CALC_WIDTH   = 64;

    localparam logic [OPCODE_WIDTH-1:0] OP_AND   = 5'd1;
    localparam logic [OPCODE_WIDTH-1:0] OP_OR    = 5'd2;
    localparam logic [OPCODE_WIDTH-1:0] OP_XOR   = 5'd3;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = 5'd4;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB   = 5'd5;
    localparam logic [OPCODE_WIDTH-1:0] OP_SRL   = 5'd6;
    localparam logic [OPCODE_WIDTH-1:0] OP_SRA   = 5'd7;
    localparam logic [OPCODE_WIDTH-1:0] OP_SLL   = 5'd8;
    localparam logic [OPCODE_WIDTH-1:0] OP_LT    = 5'd9;
    localparam logic [OPCODE_WIDTH-1:0] OP_LTU   = 5'd10;
    localparam logic [OPCODE_WIDTH-1:0] OP_EQ    = 5'd11;
    localparam logic [OPCODE_WIDTH-1:0] OP_NE    = 5'd12;
    localparam logic [OPCODE_WIDTH-1:0] OP_GE    = 5'd13;
    localparam logic [OPCODE_WIDTH-1:0] OP_GEU   = 5'd14;
    localparam logic [OPCODE_WIDTH-1:0] OP_JALR  = 5'd15;
    localparam logic [OPCODE_WIDTH-1:0] OP_MUL   = 5'd16;
    localparam logic [OPCODE_WIDTH-1:0] OP_MULHU = 5'd17;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // Operands arrive sign-extended from xlen to CALC_WIDTH bits. Sign extension
    // preserves both signed and unsigned ordering, so only SRL needs the
    // zero-extended view; callers truncate the result back to xlen (xlen <= 64).
    function automatic logic [CALC_WIDTH-1:0] alu_single(
        input logic [OPCODE_WIDTH-1:0] op,
        input logic [CALC_WIDTH-1:0]   a,
        input logic [CALC_WIDTH-1:0]   b,
        input int                      xlen
    );
        logic [CALC_WIDTH-1:0] a_zext;
        logic [5:0]            sh;
        logic [CALC_WIDTH-1:0] r;
        sh     = {1'b0, b[4:0]};
        a_zext = a & ((CALC_WIDTH'(1) << xlen) - CALC_WIDTH'(1));
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SRL:  r = a_zext >> sh;
            OP_SRA:  r = $signed(a) >>> sh;
            OP_SLL:  r = a << sh;
            OP_LT:   r = ($signed(a) < $signed(b)) ? '1 : '0;
            OP_LTU:  r = (a < b) ? '1 : '0;
            OP_EQ:   r = (a == b) ? '1 : '0;
            OP_NE:   r = (a != b) ? '1 : '0;
            OP_GE:   r = ($signed(a) >= $signed(b)) ? '1 : '0;
            OP_GEU:  r = (a >= b) ? '1 : '0;
            OP_JALR: r = (a + b) & ~CALC_WIDTH'(1);
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per enabled
// cycle, XLEN steps from start to a valid 2*XLEN product.
module alu_mul_iter #(
    parameter int XLEN = 32
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                rdy_in,
    input  logic                abort_in,
    input  logic                start_in,
    input  logic [XLEN-1:0]     a_in,
    input  logic [XLEN-1:0]     b_in,
    output logic                done_out,
    output logic                last_out,
    output logic [2*XLEN-1:0]   product_out
);

    localparam int PW    = 2 * XLEN;
    localparam int CNT_W = $clog2(XLEN + 1);

    logic [PW-1:0]    r_mcand;
    logic [XLEN-1:0]  r_mplier;
    logic [PW-1:0]    r_prod;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (rdy_in) begin
            if (abort_in) begin
                r_cnt  <= '0;
                r_busy <= 1'b0;
                r_done <= 1'b0;
            end else if (start_in) begin
                r_mcand  <= PW'(a_in);
                r_mplier <= b_in;
                r_prod   <= '0;
                r_cnt    <= CNT_W'(XLEN);
                r_busy   <= 1'b1;
                r_done   <= 1'b0;
            end else if (r_busy) begin
                if (r_mplier[0]) r_prod <= r_prod + r_mcand;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done_out    = r_done;
    assign last_out    = r_busy && (r_cnt == CNT_W'(1));
    assign product_out = r_prod;

endmodule

// File: rtl/alu_unit.sv
// Execution unit between the reservation station and the CDB: input FIFO,
// single-cycle ALU, iterative multiplier and a held valid/grant result slot.
module alu_unit
    import alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ROB_WIDTH  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    rdy_in,
    input  logic                    flush_in,
    input  logic                    cal_valid,
    output logic                    cal_ready,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [XLEN-1:0]         lhs,
    input  logic [XLEN-1:0]         rhs,
    input  logic [ROB_WIDTH-1:0]    tag,
    output logic                    done_out,
    output logic [XLEN-1:0]         result_out,
    output logic [ROB_WIDTH-1:0]    tag_out,
    input  logic                    grant_in
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [OPCODE_WIDTH-1:0] r_op_mem  [FIFO_DEPTH];
    logic [XLEN-1:0]         r_lhs_mem [FIFO_DEPTH];
    logic [XLEN-1:0]         r_rhs_mem [FIFO_DEPTH];
    logic [ROB_WIDTH-1:0]    r_tag_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]        r_count;

    state_t                  r_state;
    logic                    r_done;
    logic [XLEN-1:0]         r_result;
    logic [ROB_WIDTH-1:0]    r_tag;
    logic                    r_mul_hi;
    logic [ROB_WIDTH-1:0]    r_mul_tag;

    logic                    w_push;
    logic                    w_pop;
    logic                    w_flush;
    logic                    w_slot_free;
    logic [OPCODE_WIDTH-1:0] w_head_op;
    logic [XLEN-1:0]         w_head_lhs;
    logic [XLEN-1:0]         w_head_rhs;
    logic [ROB_WIDTH-1:0]    w_head_tag;
    logic                    w_head_is_mul;
    logic [XLEN-1:0]         w_alu_res;
    logic                    w_mul_done;
    logic                    w_mul_last;
    logic [2*XLEN-1:0]       w_product;

    assign cal_ready   = (r_count != CNT_W'(FIFO_DEPTH));
    assign w_flush     = rdy_in && flush_in;
    assign w_slot_free = !r_done || grant_in;
    assign w_push      = rdy_in && cal_valid && cal_ready && !flush_in;
    assign w_pop       = rdy_in && !flush_in && (r_state == IDLE)
                         && (r_count != '0) && w_slot_free;

    assign w_head_op     = r_op_mem[r_rd_ptr];
    assign w_head_lhs    = r_lhs_mem[r_rd_ptr];
    assign w_head_rhs    = r_rhs_mem[r_rd_ptr];
    assign w_head_tag    = r_tag_mem[r_rd_ptr];
    assign w_head_is_mul = (w_head_op == OP_MUL) || (w_head_op == OP_MULHU);
    assign w_alu_res     = XLEN'(alu_single(w_head_op,
                                            CALC_WIDTH'(signed'(w_head_lhs)),
                                            CALC_WIDTH'(signed'(w_head_rhs)),
                                            XLEN));

    // NOTE: payload storage has no reset; only pointers/count define validity,
    // so clearing the array would cost reset routing for no functional gain.
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_op_mem[r_wr_ptr]  <= opcode;
            r_lhs_mem[r_wr_ptr] <= lhs;
            r_rhs_mem[r_wr_ptr] <= rhs;
            r_tag_mem[r_wr_ptr] <= tag;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end

    alu_mul_iter #(
        .XLEN(XLEN)
    ) u_mul (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .rdy_in      (rdy_in),
        .abort_in    (w_flush),
        .start_in    (w_pop && w_head_is_mul),
        .a_in        (w_head_lhs),
        .b_in        (w_head_rhs),
        .done_out    (w_mul_done),
        .last_out    (w_mul_last),
        .product_out (w_product)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state   <= IDLE;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_tag     <= '0;
            r_mul_hi  <= 1'b0;
            r_mul_tag <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                r_state <= IDLE;
                r_done  <= 1'b0;
            end else begin
                // NOTE: a result load later in this block overrides this clear;
                // the last non-blocking assignment to r_done wins at the edge.
                if (grant_in) r_done <= 1'b0;
                case (r_state)
                    IDLE: begin
                        if (w_pop) begin
                            if (w_head_is_mul) begin
                                r_mul_hi  <= (w_head_op == OP_MULHU);
                                r_mul_tag <= w_head_tag;
                                r_state   <= BUSY;
                            end else begin
                                r_done   <= 1'b1;
                                r_result <= w_alu_res;
                                r_tag    <= w_head_tag;
                            end
                        end
                    end
                    BUSY: begin
                        if (w_mul_last) r_state <= DONE;
                    end
                    DONE: begin
                        if (w_slot_free && w_mul_done) begin
                            r_done   <= 1'b1;
                            r_result <= r_mul_hi ? w_product[2*XLEN-1:XLEN]
                                                 : w_product[XLEN-1:0];
                            r_tag    <= r_mul_tag;
                            r_state  <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign done_out   = r_done;
    assign result_out = r_result;
    assign tag_out    = r_tag;

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: expected results are queued on acceptance and
// compared when the arbiter grants them.
module tb_alu_unit;
    import alu_pkg::*;

    localparam int XLEN  = 32;
    localparam int RW    = 4;
    localparam int DEPTH = 4;

    logic            clk_in = 1'b0;
    logic            rst_n_in;
    logic            rdy_in;
    logic            flush_in;
    logic            cal_valid;
    logic            cal_ready;
    logic [4:0]      opcode;
    logic [XLEN-1:0] lhs;
    logic [XLEN-1:0] rhs;
    logic [RW-1:0]   tag;
    logic            done_out;
    logic [XLEN-1:0] result_out;
    logic [RW-1:0]   tag_out;
    logic            grant_in;

    typedef struct packed {
        logic [XLEN-1:0] res;
        logic [RW-1:0]   tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    alu_unit #(.XLEN(XLEN), .ROB_WIDTH(RW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .rdy_in     (rdy_in),
        .flush_in   (flush_in),
        .cal_valid  (cal_valid),
        .cal_ready  (cal_ready),
        .opcode     (opcode),
        .lhs        (lhs),
        .rhs        (rhs),
        .tag        (tag),
        .done_out   (done_out),
        .result_out (result_out),
        .tag_out    (tag_out),
        .grant_in   (grant_in)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [XLEN-1:0] model(input logic [4:0] op, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic [63:0] p;
        logic [4:0]  s;
        p = {32'd0, a} * {32'd0, b};
        s = b[4:0];
        case (op)
            OP_AND:   return a & b;
            OP_OR:    return a | b;
            OP_XOR:   return a ^ b;
            OP_ADD:   return a + b;
            OP_SUB:   return a - b;
            OP_SRL:   return a >> s;
            OP_SRA:   return 32'($signed(a) >>> s);
            OP_SLL:   return a << s;
            OP_LT:    return ($signed(a) < $signed(b)) ? 32'hFFFF_FFFF : 32'h0;
            OP_LTU:   return (a < b) ? 32'hFFFF_FFFF : 32'h0;
            OP_EQ:    return (a == b) ? 32'hFFFF_FFFF : 32'h0;
            OP_NE:    return (a != b) ? 32'hFFFF_FFFF : 32'h0;
            OP_GE:    return ($signed(a) >= $signed(b)) ? 32'hFFFF_FFFF : 32'h0;
            OP_GEU:   return (a >= b) ? 32'hFFFF_FFFF : 32'h0;
            OP_JALR:  return (a + b) & 32'hFFFF_FFFE;
            OP_MUL:   return p[31:0];
            OP_MULHU: return p[63:32];
            default:  return 32'h0;
        endcase
    endfunction

    // One clock: observe handshakes at the falling edge, then step past the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk_in);
        if (rst_n_in && rdy_in) begin
            if (flush_in) begin
                sb.delete();
            end else begin
                if (done_out && grant_in) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected got res=%h tag=%0d, expected none", result_out, tag_out);
                    end else begin
                        e = sb.pop_front();
                        if (result_out !== e.res || tag_out !== e.tag) begin
                            errors++;
                            $display("FAIL sb_result got res=%h tag=%0d, expected res=%h tag=%0d",
                                     result_out, tag_out, e.res, e.tag);
                        end
                    end
                end
                if (cal_valid && cal_ready) sb.push_back('{res: model(opcode, lhs, rhs), tag: tag});
            end
        end
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic set_op(input logic [4:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [RW-1:0] t);
        cal_valid = 1'b1;
        opcode    = op;
        lhs       = a;
        rhs       = b;
        tag       = t;
    endtask

    task automatic issue(input logic [4:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [RW-1:0] t);
        set_op(op, a, b, t);
        tick();
        cal_valid = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int n = 0;
        while (done_out !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        checks++;
        if (done_out !== 1'b1) begin
            errors++;
            $display("FAIL wait_done timeout after %0d cycles, done_out=%b", n, done_out);
        end
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending results, expected 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; cal_valid = 1'b0;
        opcode = '0; lhs = '0; rhs = '0; tag = '0; grant_in = 1'b1;
        #12;
        checks += 4;
        if (done_out !== 1'b0) begin errors++; $display("FAIL reset_done got %b, expected 0", done_out); end
        if (result_out !== '0) begin errors++; $display("FAIL reset_result got %h, expected 0", result_out); end
        if (tag_out !== '0) begin errors++; $display("FAIL reset_tag got %0d, expected 0", tag_out); end
        if (cal_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b, expected 1", cal_ready); end
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_add();
        grant_in = 1'b1;
        issue(OP_ADD, 32'd5, 32'd7, 4'd3);
        checks++;
        if (done_out !== 1'b0) begin errors++; $display("FAIL add_early got done=%b, expected 0", done_out); end
        tick();
        checks++;
        if (done_out !== 1'b1 || result_out !== 32'd12 || tag_out !== 4'd3) begin
            errors++;
            $display("FAIL add_latency got done=%b res=%h tag=%0d, expected 1/0000000c/3", done_out, result_out, tag_out);
        end
        tick();
        checks++;
        if (done_out !== 1'b0) begin errors++; $display("FAIL add_clear got done=%b, expected 0", done_out); end
    endtask

    task automatic test_back_to_back();
        logic [4:0]      ops [16];
        logic [XLEN-1:0] as  [16];
        logic [XLEN-1:0] bs  [16];
        ops = '{OP_SUB, OP_SRL, OP_SRA, OP_SLL, OP_LT, OP_LTU, OP_EQ, OP_NE,
                OP_GE, OP_GEU, OP_JALR, OP_XOR, OP_OR, OP_AND, 5'd0, 5'd25};
        as  = '{32'd3, 32'h8000_0000, 32'h8000_0000, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'd9, 32'd9, 32'hFFFF_FFF0, 32'h8000_0000, 32'h0000_1001, 32'hF0F0_F0F0,
                32'h1200_0034, 32'hFF00_FF00, 32'd77, 32'd77};
        bs  = '{32'd5, 32'd4, 32'd4, 32'h21, 32'd0, 32'd0, 32'd9, 32'd9, 32'd1, 32'd1,
                32'd2, 32'h0FF0_0FF0, 32'h0056_0000, 32'h0FF0_0FF0, 32'd5, 32'd5};
        grant_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            set_op(ops[i], as[i], bs[i], RW'(i));
            tick();
            if (i >= 1) begin
                checks++;
                if (done_out !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_throughput op %0d got done=%b, expected 1", i, done_out);
                end
            end
        end
        cal_valid = 1'b0;
        drain(10);
        checks++;
        if (done_out !== 1'b0) begin errors++; $display("FAIL b2b_idle got done=%b, expected 0", done_out); end
    endtask

    task automatic test_mul();
        int t0;
        grant_in = 1'b1;
        issue(OP_MUL, 32'hFFFF_FFFF, 32'd2, 4'd5);
        t0 = cyc;
        issue(OP_MULHU, 32'hFFFF_FFFF, 32'd2, 4'd6);
        wait_done(60);
        checks++;
        if (cyc != t0 + XLEN + 2 || result_out !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL mul_lo got cycle=%0d res=%h, expected cycle=%0d res=fffffffe", cyc - t0, result_out, XLEN + 2);
        end
        tick();
        wait_done(60);
        checks++;
        if (cyc != t0 + 2 * (XLEN + 2) || result_out !== 32'h0000_0001) begin
            errors++;
            $display("FAIL mul_hi got cycle=%0d res=%h, expected cycle=%0d res=00000001",
                     cyc - t0, result_out, 2 * (XLEN + 2));
        end
        tick();
    endtask

    task automatic test_backpressure();
        grant_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                checks++;
                if (cal_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_before got %b, expected 1", cal_ready); end
            end
            set_op(OP_ADD, XLEN'(i + 1), XLEN'(i * 10), RW'(8 + i));
            tick();
        end
        checks++;
        if (cal_ready !== 1'b0) begin errors++; $display("FAIL bp_full got ready=%b, expected 0", cal_ready); end
        set_op(OP_SUB, 32'd100, 32'd1, 4'd15);
        tick();
        tick();
        checks++;
        if (cal_ready !== 1'b0 || done_out !== 1'b1 || result_out !== 32'd1 || tag_out !== 4'd8) begin
            errors++;
            $display("FAIL bp_hold got ready=%b done=%b res=%h tag=%0d, expected 0/1/00000001/8",
                     cal_ready, done_out, result_out, tag_out);
        end
        cal_valid = 1'b0;
        grant_in  = 1'b1;
        for (int j = 0; j < 5; j++) begin
            checks++;
            if (done_out !== 1'b1) begin errors++; $display("FAIL bp_drain %0d got done=%b, expected 1", j, done_out); end
            tick();
        end
        checks++;
        if (done_out !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL bp_empty got done=%b pending=%0d, expected 0/0", done_out, sb.size());
        end
    endtask

    task automatic test_flush();
        bit seen = 1'b0;
        grant_in = 1'b1;
        issue(OP_MUL, 32'd3, 32'd4, 4'd1);
        issue(OP_ADD, 32'd1, 32'd1, 4'd2);
        issue(OP_ADD, 32'd2, 32'd2, 4'd3);
        repeat (3) tick();
        set_op(OP_ADD, 32'd4, 32'd4, 4'd4);
        flush_in = 1'b1;
        tick();
        flush_in  = 1'b0;
        cal_valid = 1'b0;
        checks++;
        if (cal_ready !== 1'b1 || done_out !== 1'b0) begin
            errors++;
            $display("FAIL flush_state got ready=%b done=%b, expected 1/0", cal_ready, done_out);
        end
        repeat (40) begin
            tick();
            if (done_out === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL flush_quiet got done_out=1 after flush, expected 0"); end
        issue(OP_ADD, 32'd9, 32'd9, 4'd7);
        tick();
        checks++;
        if (done_out !== 1'b1 || result_out !== 32'd18 || tag_out !== 4'd7) begin
            errors++;
            $display("FAIL flush_after got done=%b res=%h tag=%0d, expected 1/00000012/7", done_out, result_out, tag_out);
        end
        tick();
    endtask

    task automatic test_rdy_hold();
        logic [XLEN-1:0] held;
        grant_in = 1'b1;
        issue(OP_XOR, 32'hA5A5_0000, 32'h0000_5A5A, 4'd2);
        wait_done(5);
        held   = result_out;
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (done_out !== 1'b1 || result_out !== 32'hA5A5_5A5A || result_out !== held) begin
                errors++;
                $display("FAIL rdy_hold %0d got done=%b res=%h, expected 1/a5a55a5a", i, done_out, result_out);
            end
        end
        rdy_in = 1'b1;
        tick();
        checks++;
        if (done_out !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL rdy_release got done=%b pending=%0d, expected 0/0", done_out, sb.size());
        end
    endtask

    task automatic test_reset_mid_mul();
        grant_in = 1'b0;
        issue(OP_ADD, 32'd1, 32'd2, 4'd2);
        tick();
        #2;
        rst_n_in = 1'b0;
        #1;
        checks++;
        if (done_out !== 1'b0 || result_out !== '0 || tag_out !== '0) begin
            errors++;
            $display("FAIL async_clear got done=%b res=%h tag=%0d, expected 0/0/0", done_out, result_out, tag_out);
        end
        sb.delete();
        #3 rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
        grant_in = 1'b1;
        issue(OP_MUL, 32'd7, 32'd6, 4'd1);
        for (int i = 0; i < 4; i++) issue(OP_ADD, XLEN'(i), 32'd1, RW'(i));
        repeat (4) tick();
        checks++;
        if (cal_ready !== 1'b0) begin errors++; $display("FAIL mid_mul_full got ready=%b, expected 0", cal_ready); end
        #2;
        rst_n_in = 1'b0;
        #1;
        checks++;
        if (done_out !== 1'b0 || cal_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_mul_reset got done=%b ready=%b, expected 0/1", done_out, cal_ready);
        end
        sb.delete();
        #3 rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
        issue(OP_ADD, 32'd20, 32'd22, 4'd9);
        tick();
        checks++;
        if (done_out !== 1'b1 || result_out !== 32'd42 || tag_out !== 4'd9) begin
            errors++;
            $display("FAIL post_reset_op got done=%b res=%h tag=%0d, expected 1/0000002a/9", done_out, result_out, tag_out);
        end
        drain(5);
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_mul();
        test_backpressure();
        test_flush();
        test_rdy_hold();
        test_reset_mid_mul();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL final_pending got %0d, expected 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
